// File: rtl/wakeup_tag_broadcaster.sv
// Scheduler wakeup transmitter: per-lane delay lines that broadcast destination tags a fixed latency after issue.
// Optional tag cancellation is compiled in with `define RSD_WAKEUP_CANCEL_EN.
module wakeup_tag_broadcaster #(
  parameter int WAKEUP_WIDTH      = 2,
  parameter int REG_NUM_BIT_WIDTH = 7,
  parameter int MAX_LATENCY       = 4,
  parameter int LAT_BIT_WIDTH     = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [WAKEUP_WIDTH-1:0]                   i_issue,
  input  logic [WAKEUP_WIDTH-1:0]                   i_issue_dst_valid,
  input  logic [WAKEUP_WIDTH*REG_NUM_BIT_WIDTH-1:0] i_issue_dst_reg_num,
  input  logic [WAKEUP_WIDTH*LAT_BIT_WIDTH-1:0]     i_issue_latency,
  input  logic                                      i_flush,
`ifdef RSD_WAKEUP_CANCEL_EN
  input  logic                                      i_cancel,
  input  logic [REG_NUM_BIT_WIDTH-1:0]              i_cancel_reg_num,
`endif
  output logic [WAKEUP_WIDTH-1:0]                   o_wakeup,
  output logic [WAKEUP_WIDTH-1:0]                   o_wakeup_dst_valid,
  output logic [WAKEUP_WIDTH*REG_NUM_BIT_WIDTH-1:0] o_wakeup_dst_reg_num,
  output logic [WAKEUP_WIDTH*MAX_LATENCY-1:0]       o_lane_busy,
  output logic                                      o_conflict_error
);

  typedef struct packed {
    logic                         valid;
    logic                         dst_valid;
    logic [REG_NUM_BIT_WIDTH-1:0] reg_num;
  } slot_t;

  // Slot k of a lane broadcasts k cycles from now.
  slot_t                    r_slot      [WAKEUP_WIDTH][MAX_LATENCY];
  slot_t                    w_slot_next [WAKEUP_WIDTH][MAX_LATENCY];
  logic [MAX_LATENCY-1:0]   w_lane_busy [WAKEUP_WIDTH];
  logic [LAT_BIT_WIDTH-1:0] w_lat       [WAKEUP_WIDTH];
  logic                     w_conflict;
  logic                     r_conflict_error;

  // A new op with latency L lands in slot[L-1] next cycle, which is where slot[L] shifts to.
  always_comb begin
    for (int i = 0; i < WAKEUP_WIDTH; i++) begin
      w_lane_busy[i] = '0;
      for (int l = 0; l < MAX_LATENCY - 1; l++) begin
        w_lane_busy[i][l] = r_slot[i][l+1].valid;
      end
      w_lat[i] = i_issue_latency[i*LAT_BIT_WIDTH +: LAT_BIT_WIDTH];
    end
  end

  // NOTE: every signal written here gets a value on every path before any conditional update, so no latch is inferred.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < WAKEUP_WIDTH; i++) begin
      for (int k = 0; k < MAX_LATENCY - 1; k++) begin
        w_slot_next[i][k] = r_slot[i][k+1];
      end
      w_slot_next[i][MAX_LATENCY-1] = '0;
`ifdef RSD_WAKEUP_CANCEL_EN
      for (int k = 0; k < MAX_LATENCY; k++) begin
        if (i_cancel && w_slot_next[i][k].valid && w_slot_next[i][k].dst_valid &&
            (w_slot_next[i][k].reg_num == i_cancel_reg_num)) begin
          w_slot_next[i][k].valid = 1'b0;
        end
      end
`endif
      // The issue write comes last so a same-cycle tag is never cancelled.
      if (i_issue[i]) begin
        if ((w_lat[i] == '0) || (int'(w_lat[i]) > MAX_LATENCY)) begin
          w_conflict = 1'b1;
        end else begin
          for (int l = 0; l < MAX_LATENCY; l++) begin
            if (int'(w_lat[i]) == l + 1) begin
              if (w_lane_busy[i][l]) begin
                w_conflict = 1'b1;
              end else begin
                w_slot_next[i][l].valid     = 1'b1;
                w_slot_next[i][l].dst_valid = i_issue_dst_valid[i];
                w_slot_next[i][l].reg_num   =
                  i_issue_dst_reg_num[i*REG_NUM_BIT_WIDTH +: REG_NUM_BIT_WIDTH];
              end
            end
          end
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every slot shifts from its pre-edge value.
  // NOTE: the slot array is a handful of flops, not a RAM, and outputs must read zero after reset, so it is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAKEUP_WIDTH; i++) begin
        for (int k = 0; k < MAX_LATENCY; k++) begin
          r_slot[i][k] <= '0;
        end
      end
      r_conflict_error <= 1'b0;
    end else begin
      for (int i = 0; i < WAKEUP_WIDTH; i++) begin
        for (int k = 0; k < MAX_LATENCY; k++) begin
          r_slot[i][k] <= i_flush ? '0 : w_slot_next[i][k];
        end
      end
      if (w_conflict) begin
        r_conflict_error <= 1'b1;
      end
    end
  end

  always_comb begin
    o_wakeup             = '0;
    o_wakeup_dst_valid   = '0;
    o_wakeup_dst_reg_num = '0;
    o_lane_busy          = '0;
    for (int i = 0; i < WAKEUP_WIDTH; i++) begin
      o_wakeup[i]           = r_slot[i][0].valid;
      o_wakeup_dst_valid[i] = r_slot[i][0].valid && r_slot[i][0].dst_valid;
      o_wakeup_dst_reg_num[i*REG_NUM_BIT_WIDTH +: REG_NUM_BIT_WIDTH] =
        r_slot[i][0].valid ? r_slot[i][0].reg_num : '0;
      o_lane_busy[i*MAX_LATENCY +: MAX_LATENCY] = w_lane_busy[i];
    end
  end

  assign o_conflict_error = r_conflict_error;

endmodule

// File: doc/wakeup_tag_broadcaster.md
Name: wakeup_tag_broadcaster

Overview:
- Transmit side of the scheduler wakeup interface. Produces the wakeup, wakeupDstValid and wakeupDstRegNum buses that the source-operand CAMs in every issue queue compare against.
- Accepts issued ops with a destination tag and a fixed execution latency. Holds each tag in a per-lane delay line and broadcasts it exactly that many cycles after issue.
- Exports per-lane slot-reservation vectors so select logic can avoid two tags landing on the same broadcast lane in the same cycle.
- Sits between the select/issue stage and all issue-queue wakeup ports.

Parameters:
- WAKEUP_WIDTH, 2: number of issue lanes and broadcast lanes. Lane i issues only onto broadcast lane i.
- REG_NUM_BIT_WIDTH, 7: physical register tag width.
- MAX_LATENCY, 4: largest supported issue-to-wakeup latency, in cycles (must be at least 1).
- LAT_BIT_WIDTH, 3: width of the latency field. Must satisfy 2^LAT_BIT_WIDTH > MAX_LATENCY.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset.
- issue[WAKEUP_WIDTH], input, 1 each: lane i issues an op this cycle.
- issueDstValid[WAKEUP_WIDTH], input, 1 each: the issued op writes a destination register.
- issueDstRegNum[WAKEUP_WIDTH], input, REG_NUM_BIT_WIDTH each: destination physical register tag.
- issueLatency[WAKEUP_WIDTH], input, LAT_BIT_WIDTH each: requested latency L, valid range 1..MAX_LATENCY.
- flush, input, 1: discard every in-flight tag.
- wakeup[WAKEUP_WIDTH], output, 1 each: broadcast lane active this cycle.
- wakeupDstValid[WAKEUP_WIDTH], output, 1 each: the broadcast tag is a real destination.
- wakeupDstRegNum[WAKEUP_WIDTH], output, REG_NUM_BIT_WIDTH each: broadcast tag.
- laneBusy[WAKEUP_WIDTH], output, MAX_LATENCY each: bit L-1 set means issuing on this lane with latency L this cycle would collide.
- conflictError, output, 1: sticky error flag.

Interface (already decided):
- One clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- Storage: per lane, a shift register slot[0..MAX_LATENCY-1], each slot holding {valid, dstValid, regNum}.
- Every cycle, slot[k] <= slot[k+1] for k < MAX_LATENCY-1. The top slot loads invalid unless it is written by an issue.
- Issue: if issue[i] is high and L is in range, the new entry is written into slot[L-1] of the next state, overriding the shifted-in value. Latency L therefore produces wakeup[i] exactly L cycles after the issue cycle (L=1 means the next cycle).
- Outputs are driven combinationally from slot[0]:
  - wakeup[i] = slot[0].valid
  - wakeupDstValid[i] = slot[0].valid && slot[0].dstValid
  - wakeupDstRegNum[i] = slot[0].regNum when valid, otherwise 0.
- Ops issued with issueDstValid=0 still occupy their slot and raise wakeup, but wakeupDstValid stays 0.
- laneBusy[i][L-1] = slot[L].valid for L < MAX_LATENCY. laneBusy[i][MAX_LATENCY-1] is always 0. This is purely combinational and available in the same cycle as the issue request.
- Collision: issuing with latency L while laneBusy[i][L-1]=1:
  - the older in-flight entry is kept and the new op is dropped;
  - conflictError is set on the next edge and holds until rst.
- Out-of-range latency (0 or greater than MAX_LATENCY): the op is dropped and conflictError is set.
- Flush: all slots become invalid on the next edge, so all outputs are 0 from the next cycle. An issue in the same cycle as flush is dropped; flush wins. The current cycle's slot[0] is still broadcast.
- Reset: clears all slots and conflictError. All outputs are 0 the cycle after rst is sampled high, including when rst arrives mid-flight. Issues are ignored while rst is high.
- Lanes are fully independent. The same regNum may be in flight on two lanes; the CAM tolerates duplicate tags.

Optional Feature:
- Macro: RSD_WAKEUP_CANCEL_EN.
- When defined, the block adds two inputs:
  - cancel, 1 bit;
  - cancelRegNum, REG_NUM_BIT_WIDTH bits.
- When cancel is high, every in-flight slot on every lane with valid && dstValid && regNum==cancelRegNum is invalidated on the next edge. This includes slot[0] entries already shifted into position.
- A same-cycle issue with a matching tag is not cancelled.
- The current cycle's slot[0] output is unaffected.
- When the macro is not defined: no cancel ports exist, and in-flight entries are removed only by flush or rst.

Test Plan (parameters WAKEUP_WIDTH=2, MAX_LATENCY=4):
- Latency sweep: lane0 issues reg 5 with L=1, then reg 6 with L=3 two cycles later -> wakeupDstRegNum[0]=5 at cycle+1 and 6 at cycle+5, with wakeup low in all other cycles.
- Collision: at cycle 0 issue reg 10 with L=3; at cycle 1 laneBusy[0]=4'b0010; issue reg 11 with L=2 -> only reg 10 broadcasts at cycle 3, and conflictError=1 from cycle 2 onward.
- Dual-lane same cycle: lane0 issues reg 20 with L=2 and lane1 issues reg 21 with L=2 -> both wakeup lanes are active at cycle+2 with the correct tags.
- No-destination op: issue with issueDstValid=0, reg 33, L=1 -> next cycle wakeup[0]=1, wakeupDstValid[0]=0, wakeupDstRegNum[0]=33.
- Flush/reset mid-flight: three tags in flight on lane0 plus an issue with L=4 in the flush cycle -> zero wakeups afterwards. Repeat using rst instead of flush -> conflictError also cleared.
- With RSD_WAKEUP_CANCEL_EN: reg 40 (L=4) in flight on lane0 and reg 40 (L=3) on lane1; pulse cancel with cancelRegNum=40 one cycle later -> neither tag ever broadcasts, and an unrelated reg 41 in flight is still delivered.
